msrv32_machine_control: RTL

Machine-mode trap sequencer for the MSRV32 core. It watches the decoder's exception flags (illegal instruction, misaligned load/store), the fetch-stage misaligned-instruction flag, SYSTEM-instruction fields and the interrupt pending/enable bits. It sequences the core through reset, normal operation, trap entry and MRET return. It drives `trap_taken` back into the decoder, selects the PC source, and issues update strobes to the CSR file.

---
 rtl/msrv32_pkg.sv | 38 +++
 rtl/msrv32_trap_prio.sv | 80 ++++++++
 rtl/msrv32_machine_control.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the MSRV32 machine-mode trap control:
//   - FSM state encoding of the trap sequencer
//   - PC source select codes driven to the PC mux
//   - mcause exception / interrupt codes
//   - opcode[6:2] of the SYSTEM instruction class
// ---------------------------------------------------------------------------
package msrv32_pkg;

   typedef enum logic [1:0] {
      S_RESET       = 2'b00,
      S_OPERATING   = 2'b01,
      S_TRAP_TAKEN  = 2'b10,
      S_TRAP_RETURN = 2'b11
   } mc_state_t;

   localparam logic [1:0] PC_SRC_BOOT = 2'b00;
   localparam logic [1:0] PC_SRC_EPC  = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP = 2'b10;
   localparam logic [1:0] PC_SRC_NEXT = 2'b11;

   // Exception codes (mcause.interrupt = 0)
   localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
   localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   // Interrupt codes (mcause.interrupt = 1)
   localparam logic [3:0] CAUSE_M_SW_INT         = 4'd3;
   localparam logic [3:0] CAUSE_M_TIMER_INT      = 4'd7;
   localparam logic [3:0] CAUSE_M_EXT_INT        = 4'd11;

   localparam logic [4:0] OPCODE_SYSTEM          = 5'b11100;

endpackage

// File: rtl/msrv32_trap_prio.sv
// ---------------------------------------------------------------------------
// msrv32_trap_prio
// Purely combinational trap detection and prioritisation.
// Inputs : decoder/fetch exception flags, SYSTEM instruction fields,
//          mstatus.MIE, mie enables and mip pending bits.
// Outputs: exception_out  - any synchronous exception this cycle
//          interrupt_out  - an enabled interrupt is pending
//          mret_out       - the instruction is a valid MRET
//          cause_out      - winning mcause code (exception beats interrupt)
//          i_or_e_out     - 1 when the winning trap is an interrupt
// ---------------------------------------------------------------------------
module msrv32_trap_prio
   import msrv32_pkg::*;
(
   input  logic       illegal_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       misaligned_instr_in,
   input  logic [4:0] opcode_6_to_2_in,
   input  logic [2:0] funct3_in,
   input  logic [6:0] funct7_in,
   input  logic [4:0] rs1_addr_in,
   input  logic [4:0] rs2_addr_in,
   input  logic [4:0] rd_addr_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic       exception_out,
   output logic       interrupt_out,
   output logic       mret_out,
   output logic [3:0] cause_out,
   output logic       i_or_e_out
);

   logic is_system;
   logic is_ecall;
   logic is_ebreak;
   logic ext_int;
   logic sw_int;
   logic tmr_int;

   // Privileged SYSTEM encodings share funct3 = 0, rs1 = 0, rd = 0.
   // WFI is intentionally not decoded: it behaves as a NOP.
   assign is_system = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
   assign is_ecall  = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd0);
   assign is_ebreak = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd1);
   assign mret_out  = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

   assign exception_out = misaligned_instr_in | illegal_instr_in | is_ecall | is_ebreak |
                          misaligned_store_in | misaligned_load_in;

   assign ext_int = meie_in & meip_in;
   assign sw_int  = msie_in & msip_in;
   assign tmr_int = mtie_in & mtip_in;
   assign interrupt_out = mie_in & (ext_int | sw_int | tmr_int);

   always_comb begin
      cause_out  = CAUSE_MISALIGNED_INSTR;
      i_or_e_out = 1'b0;
      if (exception_out) begin
         if (misaligned_instr_in)      cause_out = CAUSE_MISALIGNED_INSTR;
         else if (illegal_instr_in)    cause_out = CAUSE_ILLEGAL;
         else if (is_ebreak)           cause_out = CAUSE_BREAKPOINT;
         else if (is_ecall)            cause_out = CAUSE_ECALL_M;
         else if (misaligned_store_in) cause_out = CAUSE_MISALIGNED_STORE;
         else                          cause_out = CAUSE_MISALIGNED_LOAD;
      end else if (interrupt_out) begin
         i_or_e_out = 1'b1;
         if (ext_int)     cause_out = CAUSE_M_EXT_INT;
         else if (sw_int) cause_out = CAUSE_M_SW_INT;
         else             cause_out = CAUSE_M_TIMER_INT;
      end
   end

endmodule

// File: rtl/msrv32_machine_control.sv
// ---------------------------------------------------------------------------
// msrv32_machine_control
// Machine-mode trap sequencer: reset -> operating -> trap entry / MRET return.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-low reset
//   *_in flags / instruction fields / MIE, mie, mip bits : trap sources
//   trap_taken_out   : combinational, exception or interrupt accepted now
//   pc_src_out       : 00 boot, 01 mepc, 10 trap vector, 11 next PC
//   flush_out        : kill the instruction in the pipeline
//   i_or_e_out, cause_out : registered mcause fields of the last trap
//   set_cause_out, set_epc_out, mie_clear_out, mie_set_out : CSR strobes
//   instret_inc_out  : retire the current instruction
// ---------------------------------------------------------------------------
module msrv32_machine_control
   import msrv32_pkg::*;
#(
   parameter int CAUSE_W = 4
) (
   input  logic               ms_riscv32_mp_clk_in,
   input  logic               ms_riscv32_mp_rst_in,
   input  logic               illegal_instr_in,
   input  logic               misaligned_load_in,
   input  logic               misaligned_store_in,
   input  logic               misaligned_instr_in,
   input  logic [4:0]         opcode_6_to_2_in,
   input  logic [2:0]         funct3_in,
   input  logic [6:0]         funct7_in,
   input  logic [4:0]         rs1_addr_in,
   input  logic [4:0]         rs2_addr_in,
   input  logic [4:0]         rd_addr_in,
   input  logic               mie_in,
   input  logic               meie_in,
   input  logic               mtie_in,
   input  logic               msie_in,
   input  logic               meip_in,
   input  logic               mtip_in,
   input  logic               msip_in,
   output logic               trap_taken_out,
   output logic [1:0]         pc_src_out,
   output logic               flush_out,
   output logic               i_or_e_out,
   output logic [CAUSE_W-1:0] cause_out,
   output logic               set_cause_out,
   output logic               set_epc_out,
   output logic               mie_clear_out,
   output logic               mie_set_out,
   output logic               instret_inc_out
);

   mc_state_t          state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               i_or_e_q, i_or_e_d;

   logic               exception;
   logic               interrupt;
   logic               mret;
   logic [3:0]         trap_cause;
   logic               trap_i_or_e;

   msrv32_trap_prio u_trap_prio (
      .illegal_instr_in    (illegal_instr_in),
      .misaligned_load_in  (misaligned_load_in),
      .misaligned_store_in (misaligned_store_in),
      .misaligned_instr_in (misaligned_instr_in),
      .opcode_6_to_2_in    (opcode_6_to_2_in),
      .funct3_in           (funct3_in),
      .funct7_in           (funct7_in),
      .rs1_addr_in         (rs1_addr_in),
      .rs2_addr_in         (rs2_addr_in),
      .rd_addr_in          (rd_addr_in),
      .mie_in              (mie_in),
      .meie_in             (meie_in),
      .mtie_in             (mtie_in),
      .msie_in             (msie_in),
      .meip_in             (meip_in),
      .mtip_in             (mtip_in),
      .msip_in             (msip_in),
      .exception_out       (exception),
      .interrupt_out       (interrupt),
      .mret_out            (mret),
      .cause_out           (trap_cause),
      .i_or_e_out          (trap_i_or_e)
   );

   always_comb begin
      state_d         = state_q;
      cause_d         = cause_q;
      i_or_e_d        = i_or_e_q;
      trap_taken_out  = 1'b0;
      pc_src_out      = PC_SRC_NEXT;
      flush_out       = 1'b0;
      set_cause_out   = 1'b0;
      set_epc_out     = 1'b0;
      mie_clear_out   = 1'b0;
      mie_set_out     = 1'b0;
      instret_inc_out = 1'b0;
      case (state_q)
         S_RESET: begin
            pc_src_out = PC_SRC_BOOT;
            flush_out  = 1'b1;
            state_d    = S_OPERATING;
         end
         S_OPERATING: begin
            pc_src_out = PC_SRC_NEXT;
            // A faulting instruction does not retire; an interrupted one does.
            instret_inc_out = ~exception;
            if (exception | interrupt) begin
               trap_taken_out = 1'b1;
               cause_d        = CAUSE_W'(trap_cause);
               i_or_e_d       = trap_i_or_e;
               state_d        = S_TRAP_TAKEN;
            end else if (mret) begin
               state_d = S_TRAP_RETURN;
            end
         end
         S_TRAP_TAKEN: begin
            pc_src_out    = PC_SRC_TRAP;
            set_cause_out = 1'b1;
            set_epc_out   = 1'b1;
            mie_clear_out = 1'b1;
            flush_out     = 1'b1;
            state_d       = S_OPERATING;
         end
         S_TRAP_RETURN: begin
            pc_src_out  = PC_SRC_EPC;
            mie_set_out = 1'b1;
            flush_out   = 1'b1;
            state_d     = S_OPERATING;
         end
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state_q  <= S_RESET;
         cause_q  <= '0;
         i_or_e_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         i_or_e_q <= i_or_e_d;
      end
   end

   assign cause_out  = cause_q;
   assign i_or_e_out = i_or_e_q;

endmodule
